// File: rtl/acc_dp_pkg.sv
// Shared definitions for the accumulator datapath: opcode encodings,
// FSM state encoding and the immediate sign-extension helper.
package acc_dp_pkg;

    localparam logic [3:0] OPC_NOP = 4'd0;
    localparam logic [3:0] OPC_LD  = 4'd1;
    localparam logic [3:0] OPC_ST  = 4'd2;
    localparam logic [3:0] OPC_ADD = 4'd3;
    localparam logic [3:0] OPC_SUB = 4'd4;
    localparam logic [3:0] OPC_AND = 4'd5;
    localparam logic [3:0] OPC_OR  = 4'd6;
    localparam logic [3:0] OPC_XOR = 4'd7;
    localparam logic [3:0] OPC_SHL = 4'd8;
    localparam logic [3:0] OPC_SHR = 4'd9;
    localparam logic [3:0] OPC_MUL = 4'd10;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_MUL_RUN = 1'b1;

    // Replicates bit (width-1) of value into every higher bit position.
    function automatic logic [31:0] sign_extend(input logic [31:0] value, input int width);
        logic [31:0] result;
        result = '0;
        for (int i = 0; i < 32; i++) begin
            result[i] = (i < width) ? value[i] : value[width-1];
        end
        return result;
    endfunction

endpackage

// File: rtl/acc_datapath_mc_seq_multiplier.sv
// Shift-add unsigned multiplier used by the accumulator datapath.
// Compiled only when ACC_DP_MUL_EN is defined.
// One partial product is added per cycle while busy; o_last marks the final
// step, during which o_product already shows the complete product.
`ifdef ACC_DP_MUL_EN
module seq_multiplier
    import acc_dp_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [DATA_W-1:0]     i_multiplicand,
    input  logic [DATA_W-1:0]     i_multiplier,
    output logic                  o_busy,
    output logic                  o_last,
    output logic [2*DATA_W-1:0]   o_product
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [2*DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0]   r_mplier;
    logic [2*DATA_W-1:0] r_prod;
    logic [CNT_W-1:0]    r_count;
    logic                r_busy;
    logic [2*DATA_W-1:0] w_nextProd;

    // Partial sum including the current step, so the final result is visible on the last cycle.
    always_comb begin
        w_nextProd = r_prod + (r_mplier[0] ? r_mcand : '0);
    end

    assign o_busy    = r_busy;
    assign o_last    = r_busy && (r_count == CNT_W'(DATA_W-1));
    assign o_product = w_nextProd;

    // Load operands on start, then shift multiplicand left and multiplier right each step.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_count  <= '0;
            r_busy   <= 1'b0;
        end else if (i_start && !r_busy) begin
            r_mcand  <= {{DATA_W{1'b0}}, i_multiplicand};
            r_mplier <= i_multiplier;
            r_prod   <= '0;
            r_count  <= '0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_prod   <= w_nextProd;
            r_mcand  <= {r_mcand[2*DATA_W-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[DATA_W-1:1]};
            r_count  <= r_count + 1'b1;
            if (o_last) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule
`endif

// File: rtl/acc_datapath_mc.sv
// Multi-cycle accumulator datapath for the BIP-style CPU core.
// Accepts one opcode per valid/ready handshake and updates acc and Z/N/C flags.
// ACC_DP_MUL_EN: when defined, opcode MUL runs on the sequential multiplier
// (OpReady low while it runs); when undefined MUL is treated as illegal.
module acc_datapath_mc
    import acc_dp_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 11
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_opValid,
    output logic              o_opReady,
    input  logic [3:0]        i_opCode,
    input  logic              i_selB,
    input  logic [IMM_W-1:0]  i_addr,
    input  logic [DATA_W-1:0] i_outData,
    output logic [DATA_W-1:0] o_inData,
    output logic              o_memWr,
    output logic              o_done,
    output logic              o_illegalOp,
    output logic              o_zero,
    output logic              o_neg,
    output logic              o_carry
);

    logic [DATA_W-1:0] r_acc;
    logic              r_zero;
    logic              r_neg;
    logic              r_carry;
    logic              r_done;
    logic              r_memWr;
    logic              r_illegal;

    logic [DATA_W-1:0] w_immExt;
    logic [DATA_W-1:0] w_operandB;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_diff;
    logic [DATA_W-1:0] w_result;
    logic              w_carry;
    logic              w_writeAcc;
    logic              w_isStore;
    logic              w_isIllegal;
    logic              w_isMul;
    logic              w_accept;

    assign w_immExt   = DATA_W'(sign_extend(32'(i_addr), IMM_W));
    assign w_operandB = i_selB ? w_immExt : i_outData;
    assign w_sum      = {1'b0, r_acc} + {1'b0, w_operandB};
    assign w_diff     = {1'b0, r_acc} + {1'b0, ~w_operandB} + {{DATA_W{1'b0}}, 1'b1};
    assign w_accept   = i_opValid && o_opReady;

    // Combinational ALU: result, carry and side-effect decode for the current opcode.
    always_comb begin
        w_result    = r_acc;
        w_carry     = 1'b0;
        w_writeAcc  = 1'b0;
        w_isStore   = 1'b0;
        w_isIllegal = 1'b0;
        w_isMul     = 1'b0;
        case (i_opCode)
            OPC_NOP: ;
            OPC_LD:  begin w_result = w_operandB; w_writeAcc = 1'b1; end
            OPC_ST:  w_isStore = 1'b1;
            OPC_ADD: begin w_result = w_sum[DATA_W-1:0]; w_carry = w_sum[DATA_W]; w_writeAcc = 1'b1; end
            OPC_SUB: begin w_result = w_diff[DATA_W-1:0]; w_carry = w_diff[DATA_W]; w_writeAcc = 1'b1; end
            OPC_AND: begin w_result = r_acc & w_operandB; w_writeAcc = 1'b1; end
            OPC_OR:  begin w_result = r_acc | w_operandB; w_writeAcc = 1'b1; end
            OPC_XOR: begin w_result = r_acc ^ w_operandB; w_writeAcc = 1'b1; end
            OPC_SHL: begin
                w_result   = {r_acc[DATA_W-2:0], 1'b0};
                w_carry    = r_acc[DATA_W-1];
                w_writeAcc = 1'b1;
            end
            OPC_SHR: begin
                w_result   = {r_acc[DATA_W-1], r_acc[DATA_W-1:1]};
                w_carry    = r_acc[0];
                w_writeAcc = 1'b1;
            end
`ifdef ACC_DP_MUL_EN
            OPC_MUL: w_isMul = 1'b1;
`endif
            default: w_isIllegal = 1'b1;
        endcase
    end

`ifdef ACC_DP_MUL_EN
    logic [0:0]          r_state;
    logic                w_mulBusy;
    logic                w_mulLast;
    logic [2*DATA_W-1:0] w_mulProd;

    seq_multiplier #(
        .DATA_W (DATA_W)
    ) u_mul (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_start        (w_accept && w_isMul),
        .i_multiplicand (r_acc),
        .i_multiplier   (w_operandB),
        .o_busy         (w_mulBusy),
        .o_last         (w_mulLast),
        .o_product      (w_mulProd)
    );

    assign o_opReady = (r_state == ST_IDLE) && !w_mulBusy;

    // Accumulator, flags, strobes and the IDLE/MUL_RUN state; a multiply writes back on its last step.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_acc     <= '0;
            r_zero    <= 1'b1;
            r_neg     <= 1'b0;
            r_carry   <= 1'b0;
            r_done    <= 1'b0;
            r_memWr   <= 1'b0;
            r_illegal <= 1'b0;
            r_state   <= ST_IDLE;
        end else begin
            r_done    <= 1'b0;
            r_memWr   <= 1'b0;
            r_illegal <= 1'b0;
            if (w_accept) begin
                if (w_isMul) begin
                    r_state <= ST_MUL_RUN;
                end else begin
                    r_done    <= 1'b1;
                    r_memWr   <= w_isStore;
                    r_illegal <= w_isIllegal;
                    if (w_writeAcc) begin
                        r_acc   <= w_result;
                        r_zero  <= (w_result == '0);
                        r_neg   <= w_result[DATA_W-1];
                        r_carry <= w_carry;
                    end
                end
            end else if (r_state == ST_MUL_RUN && w_mulLast) begin
                r_acc   <= w_mulProd[DATA_W-1:0];
                r_zero  <= (w_mulProd[DATA_W-1:0] == '0);
                r_neg   <= w_mulProd[DATA_W-1];
                r_carry <= |w_mulProd[2*DATA_W-1:DATA_W];
                r_done  <= 1'b1;
                r_state <= ST_IDLE;
            end
        end
    end
`else
    assign o_opReady = 1'b1;

    // Accumulator, flags and strobes; every request completes in one cycle.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_acc     <= '0;
            r_zero    <= 1'b1;
            r_neg     <= 1'b0;
            r_carry   <= 1'b0;
            r_done    <= 1'b0;
            r_memWr   <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_memWr   <= 1'b0;
            r_illegal <= 1'b0;
            if (w_accept) begin
                r_done    <= 1'b1;
                r_memWr   <= w_isStore;
                r_illegal <= w_isIllegal;
                if (w_writeAcc) begin
                    r_acc   <= w_result;
                    r_zero  <= (w_result == '0);
                    r_neg   <= w_result[DATA_W-1];
                    r_carry <= w_carry;
                end
            end
        end
    end
`endif

    assign o_inData    = r_acc;
    assign o_memWr     = r_memWr;
    assign o_done      = r_done;
    assign o_illegalOp = r_illegal;
    assign o_zero      = r_zero;
    assign o_neg       = r_neg;
    assign o_carry     = r_carry;

endmodule

// File: tb/tb_acc_datapath_mc.sv
// Directed self-checking bench for acc_datapath_mc at DATA_W=16, IMM_W=11.
// Works with and without ACC_DP_MUL_EN; multiply expectations follow the build.
module tb_acc_datapath_mc;

    logic        clock = 1'b0;
    logic        reset;
    logic        opValid;
    logic        opReady;
    logic [3:0]  opCode;
    logic        selB;
    logic [10:0] addr;
    logic [15:0] outData;
    logic [15:0] inData;
    logic        memWr;
    logic        done;
    logic        illegalOp;
    logic        zero;
    logic        neg;
    logic        carry;

    int checkCount = 0;
    int passCount  = 0;

    acc_datapath_mc #(.DATA_W(16), .IMM_W(11)) dut (
        .i_clock     (clock),
        .i_reset     (reset),
        .i_opValid   (opValid),
        .o_opReady   (opReady),
        .i_opCode    (opCode),
        .i_selB      (selB),
        .i_addr      (addr),
        .i_outData   (outData),
        .o_inData    (inData),
        .o_memWr     (memWr),
        .o_done      (done),
        .o_illegalOp (illegalOp),
        .o_zero      (zero),
        .o_neg       (neg),
        .o_carry     (carry)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Presents one request for a single accepting edge, then drops OpValid.
    task automatic issue(input logic [3:0] op, input logic sb, input logic [10:0] a, input logic [15:0] d);
        opValid = 1'b1; opCode = op; selB = sb; addr = a; outData = d;
        tick();
        opValid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; opValid = 1'b0; opCode = 4'd0; selB = 1'b0; addr = '0; outData = '0;
        tick(); tick();
        reset = 1'b0;
        checkCount++; if (inData !== 16'h0000) $display("[TB] FAIL reset_acc: got %h want %h", inData, 16'h0000); else passCount++;
        checkCount++; if ({zero, neg, carry} !== 3'b100) $display("[TB] FAIL reset_flags: got %b want %b", {zero, neg, carry}, 3'b100);
                      else passCount++;
        checkCount++; if ({opReady, memWr, done, illegalOp} !== 4'b1000)
                          $display("[TB] FAIL reset_ctrl: got %b want %b", {opReady, memWr, done, illegalOp}, 4'b1000);
                      else passCount++;
    endtask

    task automatic test_load();
        issue(4'd1, 1'b1, 11'h7FF, 16'h0000);
        checkCount++; if (done !== 1'b1) $display("[TB] FAIL ld_done: got %b want 1", done); else passCount++;
        checkCount++; if (inData !== 16'hFFFF) $display("[TB] FAIL ld_acc: got %h want %h", inData, 16'hFFFF); else passCount++;
        checkCount++; if ({zero, neg, carry} !== 3'b010) $display("[TB] FAIL ld_flags: got %b want %b", {zero, neg, carry}, 3'b010);
                      else passCount++;
        tick();
        checkCount++; if (done !== 1'b0) $display("[TB] FAIL ld_done_pulse: got %b want 0", done); else passCount++;
    endtask

    task automatic test_add_sub();
        issue(4'd3, 1'b1, 11'h001, 16'h0000);
        checkCount++; if (inData !== 16'h0000) $display("[TB] FAIL add_acc: got %h want %h", inData, 16'h0000); else passCount++;
        checkCount++; if ({zero, neg, carry} !== 3'b101) $display("[TB] FAIL add_flags: got %b want %b", {zero, neg, carry}, 3'b101);
                      else passCount++;
        issue(4'd4, 1'b1, 11'h001, 16'h0000);
        checkCount++; if (inData !== 16'hFFFF) $display("[TB] FAIL sub_acc: got %h want %h", inData, 16'hFFFF); else passCount++;
        checkCount++; if ({zero, neg, carry} !== 3'b010) $display("[TB] FAIL sub_flags: got %b want %b", {zero, neg, carry}, 3'b010);
                      else passCount++;
    endtask

    task automatic test_shift();
        issue(4'd1, 1'b0, 11'h000, 16'h8001);
        issue(4'd9, 1'b0, 11'h000, 16'h0000);
        checkCount++; if (inData !== 16'hC000) $display("[TB] FAIL shr_acc: got %h want %h", inData, 16'hC000); else passCount++;
        checkCount++; if ({zero, neg, carry} !== 3'b011) $display("[TB] FAIL shr_flags: got %b want %b", {zero, neg, carry}, 3'b011);
                      else passCount++;
        issue(4'd8, 1'b0, 11'h000, 16'h0000);
        checkCount++; if (inData !== 16'h8000) $display("[TB] FAIL shl_acc: got %h want %h", inData, 16'h8000); else passCount++;
        checkCount++; if ({zero, neg, carry} !== 3'b011) $display("[TB] FAIL shl_flags: got %b want %b", {zero, neg, carry}, 3'b011);
                      else passCount++;
    endtask

    task automatic test_back_to_back();
        // LD 10, ADD 5, AND 00FA, OR F000, XOR F00A on consecutive edges.
        logic [3:0]  ops  [5] = '{4'd1, 4'd3, 4'd5, 4'd6, 4'd7};
        logic [15:0] data [5] = '{16'h000A, 16'h0005, 16'h00FA, 16'hF000, 16'hF00A};
        logic [15:0] accs [5] = '{16'h000A, 16'h000F, 16'h000A, 16'hF00A, 16'h0000};
        logic [2:0]  flgs [5] = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b100};
        for (int i = 0; i < 5; i++) begin
            opValid = 1'b1; opCode = ops[i]; selB = 1'b0; outData = data[i];
            tick();
            checkCount++;
            if (inData !== accs[i] || {zero, neg, carry} !== flgs[i] || done !== 1'b1)
                $display("[TB] FAIL b2b_%0d: got acc %h flags %b done %b want acc %h flags %b done 1",
                         i, inData, {zero, neg, carry}, done, accs[i], flgs[i]);
            else passCount++;
        end
        opValid = 1'b0;
    endtask

    task automatic test_mul();
        bit readyOk = 1'b1;
        issue(4'd1, 1'b1, 11'd300, 16'h0000);
        issue(4'd10, 1'b0, 11'h000, 16'd300);
`ifdef ACC_DP_MUL_EN
        // Hold a competing LD during the busy window; it must not be taken.
        opValid = 1'b1; opCode = 4'd1; selB = 1'b1; addr = 11'h055;
        for (int k = 1; k <= 16; k++) begin
            if (opReady !== 1'b0 || done !== 1'b0) readyOk = 1'b0;
            if (k == 16) opValid = 1'b0;
            tick();
        end
        checkCount++; if (readyOk !== 1'b1) $display("[TB] FAIL mul_busy: got ready/done activity want 16 idle cycles"); else passCount++;
        checkCount++; if ({done, opReady} !== 2'b11) $display("[TB] FAIL mul_done: got %b want %b", {done, opReady}, 2'b11);
                      else passCount++;
        checkCount++; if (inData !== 16'h5F90) $display("[TB] FAIL mul_acc: got %h want %h", inData, 16'h5F90); else passCount++;
        checkCount++; if ({zero, neg, carry} !== 3'b001) $display("[TB] FAIL mul_flags: got %b want %b", {zero, neg, carry}, 3'b001);
                      else passCount++;
        tick();
        checkCount++; if (inData !== 16'h5F90) $display("[TB] FAIL mul_hold_not_taken: got %h want %h", inData, 16'h5F90);
                      else passCount++;
`else
        checkCount++; if ({illegalOp, done} !== 2'b11) $display("[TB] FAIL mul_illegal: got %b want %b", {illegalOp, done}, 2'b11);
                      else passCount++;
        checkCount++; if (inData !== 16'd300) $display("[TB] FAIL mul_acc_held: got %h want %h", inData, 16'd300); else passCount++;
        checkCount++; if (readyOk !== 1'b1 || opReady !== 1'b1) $display("[TB] FAIL mul_ready: got %b want 1", opReady);
                      else passCount++;
`endif
    endtask

    task automatic test_mul_reset();
        bit sawDone = 1'b0;
        issue(4'd1, 1'b1, 11'd5, 16'h0000);
        issue(4'd10, 1'b1, 11'd3, 16'h0000);
        for (int k = 1; k < 5; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkCount++; if ({opReady, done} !== 2'b10) $display("[TB] FAIL mulrst_ctrl: got %b want %b", {opReady, done}, 2'b10);
                      else passCount++;
        for (int k = 0; k < 14; k++) begin
            if (done !== 1'b0) sawDone = 1'b1;
            tick();
        end
        checkCount++; if (inData !== 16'h0000 || sawDone !== 1'b0)
                          $display("[TB] FAIL mulrst_no_write: got acc %h done_seen %b want acc 0000 done_seen 0", inData, sawDone);
                      else passCount++;
    endtask

    task automatic test_store_illegal();
        issue(4'd1, 1'b0, 11'h000, 16'h1234);
        issue(4'd2, 1'b0, 11'h000, 16'hAAAA);
        checkCount++; if ({memWr, done} !== 2'b11 || inData !== 16'h1234)
                          $display("[TB] FAIL st_write: got memWr %b data %h want memWr 1 data %h", memWr, inData, 16'h1234);
                      else passCount++;
        tick();
        checkCount++; if (memWr !== 1'b0) $display("[TB] FAIL st_pulse: got %b want 0", memWr); else passCount++;
        issue(4'd1, 1'b0, 11'h000, 16'hFFFF);
        issue(4'd3, 1'b0, 11'h000, 16'h0001);
        issue(4'd13, 1'b0, 11'h000, 16'h5555);
        checkCount++; if ({illegalOp, done} !== 2'b11) $display("[TB] FAIL ill_pulse: got %b want %b", {illegalOp, done}, 2'b11);
                      else passCount++;
        checkCount++; if ({zero, neg, carry} !== 3'b101 || inData !== 16'h0000)
                          $display("[TB] FAIL ill_held: got flags %b acc %h want flags 101 acc 0000", {zero, neg, carry}, inData);
                      else passCount++;
        tick();
        checkCount++; if (illegalOp !== 1'b0) $display("[TB] FAIL ill_clear: got %b want 0", illegalOp); else passCount++;
    endtask

    initial begin
        test_reset();
        test_load();
        test_add_sub();
        test_shift();
        test_back_to_back();
        test_mul();
        test_mul_reset();
        test_store_illegal();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
